io_bridge: RTL and testbench

//  Parametrised successor to the single-target IO port between the MMU and peripherals.

---
 rtl/io_bridge_pkg.sv | 20 ++
 rtl/io_bridge_if.sv | 42 ++++
 rtl/io_wait_timer.sv | 27 ++
 rtl/io_bridge.sv | 158 +++++++++++++++
 tb/tb_io_bridge.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared state encodings, widths and helpers for io_bridge
package io_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 16;

    // Failed-access counter sticks at all-ones instead of wrapping
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value,
                                                     input logic                 inc);
        if (inc && (value != {ERR_CNT_W{1'b1}}))
            return value + 1'b1;
        return value;
    endfunction

endpackage

// File: rtl/io_bridge_if.sv
// rtl/io_bridge_if.sv - MMU-side and peripheral-side signal bundle for io_bridge
interface io_bridge_if #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int NUM_DEV    = 4,
    parameter int DEV_ADDR_W = 6
);
    import io_bridge_pkg::*;

    // MMU side
    logic [ADDR_W-1:0]         io_addr;
    logic                      io_en;
    logic                      io_we;
    logic [DATA_W-1:0]         io_data_write;
    logic [DATA_W-1:0]         io_data_read;
    logic                      io_ready;
    logic                      io_err;
    logic [ERR_CNT_W-1:0]      err_count;

    // Peripheral side
    logic [NUM_DEV-1:0]        dev_sel;
    logic                      dev_we;
    logic [DEV_ADDR_W-1:0]     dev_addr;
    logic [DATA_W-1:0]         dev_wdata;
    logic [NUM_DEV*DATA_W-1:0] dev_rdata;
    logic [NUM_DEV-1:0]        dev_ack;

    // Bridge view
    modport slave (
        input  io_addr, io_en, io_we, io_data_write, dev_rdata, dev_ack,
        output io_data_read, io_ready, io_err, err_count,
               dev_sel, dev_we, dev_addr, dev_wdata
    );

    // Environment view: the MMU plus the peripheral set
    modport master (
        output io_addr, io_en, io_we, io_data_write, dev_rdata, dev_ack,
        input  io_data_read, io_ready, io_err, err_count,
               dev_sel, dev_we, dev_addr, dev_wdata
    );

endinterface

// File: rtl/io_wait_timer.sv
// rtl/io_wait_timer.sv - device wait-state counter with terminal flag at TIMEOUT-1
module io_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_term
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TERM_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Count WAIT cycles without an ack; cleared while the bridge is idle
    always_ff @(posedge clk) begin
        if (reset || i_clear)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + 1'b1;
    end

    assign o_term = (r_count == TERM_VAL);

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - decodes MMU IO accesses onto NUM_DEV peripherals with ack and timeout
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int NUM_DEV    = 4,
    parameter int DEV_ADDR_W = 6,
    parameter int TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       reset,
    io_bridge_if.slave bus
);

    localparam int               IDX_W     = ADDR_W - DEV_ADDR_W;
    // One extra bit so NUM_DEV == 2**IDX_W is representable in the compare
    localparam logic [IDX_W:0]   NUM_DEV_L = (IDX_W + 1)'(NUM_DEV);

    state_t                r_state,        w_state_next;
    logic [NUM_DEV-1:0]    r_dev_sel,      w_dev_sel_next;
    logic                  r_dev_we,       w_dev_we_next;
    logic [DEV_ADDR_W-1:0] r_dev_addr,     w_dev_addr_next;
    logic [DATA_W-1:0]     r_dev_wdata,    w_dev_wdata_next;
    logic [DATA_W-1:0]     r_io_data_read, w_io_data_read_next;
    logic                  r_io_ready,     w_io_ready_next;
    logic                  r_io_err,       w_io_err_next;
    logic [ERR_CNT_W-1:0]  r_err_count,    w_err_count_next;

    logic [IDX_W-1:0]      w_index;
    logic                  w_index_ok;
    logic [NUM_DEV-1:0]    w_onehot;
    logic                  w_ack;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_timer_clear;
    logic                  w_timer_en;
    logic                  w_timer_term;

    io_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_timer_clear),
        .i_en    (w_timer_en),
        .o_term  (w_timer_term)
    );

    // Address decode plus ack/read-data mux gated by the latched one-hot select
    always_comb begin
        w_index    = bus.io_addr[ADDR_W-1:DEV_ADDR_W];
        w_index_ok = ({1'b0, w_index} < NUM_DEV_L);
        w_onehot   = '0;
        w_ack      = 1'b0;
        w_rdata    = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            w_onehot[i] = (w_index == IDX_W'(i));
            if (r_dev_sel[i]) begin
                w_ack   = w_ack | bus.dev_ack[i];
                w_rdata = w_rdata | bus.dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        w_state_next        = r_state;
        w_dev_sel_next      = r_dev_sel;
        w_dev_we_next       = r_dev_we;
        w_dev_addr_next     = r_dev_addr;
        w_dev_wdata_next    = r_dev_wdata;
        w_io_data_read_next = r_io_data_read;
        w_io_ready_next     = 1'b0;
        w_io_err_next       = 1'b0;
        w_err_count_next    = r_err_count;
        w_timer_clear       = 1'b0;
        w_timer_en          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_timer_clear = 1'b1;
                if (bus.io_en) begin
                    w_dev_addr_next  = bus.io_addr[DEV_ADDR_W-1:0];
                    w_dev_wdata_next = bus.io_data_write;
                    if (w_index_ok) begin
                        w_state_next   = ST_WAIT;
                        w_dev_sel_next = w_onehot;
                        w_dev_we_next  = bus.io_we;
                    end else begin
                        w_state_next        = ST_RESP;
                        w_io_ready_next     = 1'b1;
                        w_io_err_next       = 1'b1;
                        w_io_data_read_next = '0;
                    end
                end
            end
            ST_WAIT: begin
                // An ack arriving on the timeout cycle still completes cleanly
                if (w_ack) begin
                    w_state_next        = ST_RESP;
                    w_io_ready_next     = 1'b1;
                    w_io_data_read_next = r_dev_we ? '0 : w_rdata;
                end else if (w_timer_term) begin
                    w_state_next        = ST_RESP;
                    w_io_ready_next     = 1'b1;
                    w_io_err_next       = 1'b1;
                    w_io_data_read_next = '0;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            ST_RESP: begin
                // Select drops on leaving RESP, leaving one idle cycle between back-to-back selects
                w_state_next     = ST_IDLE;
                w_dev_sel_next   = '0;
                w_dev_we_next    = 1'b0;
                w_err_count_next = sat_inc(r_err_count, r_io_err);
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_dev_sel      <= '0;
            r_dev_we       <= 1'b0;
            r_dev_addr     <= '0;
            r_dev_wdata    <= '0;
            r_io_data_read <= '0;
            r_io_ready     <= 1'b0;
            r_io_err       <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_state        <= w_state_next;
            r_dev_sel      <= w_dev_sel_next;
            r_dev_we       <= w_dev_we_next;
            r_dev_addr     <= w_dev_addr_next;
            r_dev_wdata    <= w_dev_wdata_next;
            r_io_data_read <= w_io_data_read_next;
            r_io_ready     <= w_io_ready_next;
            r_io_err       <= w_io_err_next;
            r_err_count    <= w_err_count_next;
        end
    end

    assign bus.dev_sel      = r_dev_sel;
    assign bus.dev_we       = r_dev_we;
    assign bus.dev_addr     = r_dev_addr;
    assign bus.dev_wdata    = r_dev_wdata;
    assign bus.io_data_read = r_io_data_read;
    assign bus.io_ready     = r_io_ready;
    assign bus.io_err       = r_io_err;
    assign bus.err_count    = r_err_count;

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - scoreboard bench for io_bridge with a 4-device and a 3-device instance
module tb_io_bridge;
    import io_bridge_pkg::*;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int DEV_ADDR_W = 6;
    localparam int TIMEOUT    = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    io_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DEV(4), .DEV_ADDR_W(DEV_ADDR_W)) if4 ();
    io_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DEV(3), .DEV_ADDR_W(DEV_ADDR_W)) if3 ();

    io_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DEV(4), .DEV_ADDR_W(DEV_ADDR_W),
                .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(if4));
    io_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DEV(3), .DEV_ADDR_W(DEV_ADDR_W),
                .TIMEOUT(TIMEOUT)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    logic [ADDR_W-1:0]   tb_addr;
    logic                tb_we;
    logic [DATA_W-1:0]   tb_wdata;
    logic                tb_en;
    logic                tgt3;
    logic [3:0]          tb_ack;
    logic [4*DATA_W-1:0] tb_rdata;

    assign if4.io_addr       = tb_addr;
    assign if4.io_we         = tb_we;
    assign if4.io_data_write = tb_wdata;
    assign if4.io_en         = tb_en & ~tgt3;
    assign if4.dev_ack       = tb_ack;
    assign if4.dev_rdata     = tb_rdata;
    assign if3.io_addr       = tb_addr;
    assign if3.io_we         = tb_we;
    assign if3.io_data_write = tb_wdata;
    assign if3.io_en         = tb_en & tgt3;
    assign if3.dev_ack       = tb_ack[2:0];
    assign if3.dev_rdata     = tb_rdata[3*DATA_W-1:0];

    logic        obs_ready, obs_err, obs_we;
    logic [31:0] obs_rdata, obs_wdata;
    logic [15:0] obs_cnt;
    logic [3:0]  obs_sel;
    logic [5:0]  obs_addr;

    always_comb begin
        if (tgt3) begin
            obs_ready = if3.io_ready;  obs_err   = if3.io_err;     obs_we   = if3.dev_we;
            obs_rdata = if3.io_data_read; obs_wdata = if3.dev_wdata; obs_cnt = if3.err_count;
            obs_sel   = {1'b0, if3.dev_sel}; obs_addr = if3.dev_addr;
        end else begin
            obs_ready = if4.io_ready;  obs_err   = if4.io_err;     obs_we   = if4.dev_we;
            obs_rdata = if4.io_data_read; obs_wdata = if4.dev_wdata; obs_cnt = if4.err_count;
            obs_sel   = if4.dev_sel;   obs_addr  = if4.dev_addr;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] exp_cnt4;
    logic [15:0] exp_cnt3;

    // d = wait cycles before the ack (d < 0: never acked); stray holds dev_ack[3] high throughout
    task automatic do_access(input logic t3, input logic [7:0] addr, input logic we,
                             input logic [31:0] wdata, input int d, input logic [31:0] rval,
                             input logic stray);
        int   idx;
        int   nd;
        logic bad;
        logic seen;
        exp_t e;
        exp_t got;
        idx = int'(addr[7:6]);
        nd  = t3 ? 3 : 4;
        bad = (idx >= nd);
        @(negedge clk);
        tgt3 = t3; tb_addr = addr; tb_we = we; tb_wdata = wdata; tb_en = 1'b1; tb_ack = '0;
        for (int i = 0; i < 4; i++) tb_rdata[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
        tb_rdata[idx*32 +: 32] = rval;
        e.err  = bad || (d < 0);
        e.data = (e.err || we) ? 32'h0 : rval;
        e.lat  = bad ? 1 : ((d < 0) ? TIMEOUT + 1 : 2 + d);
        sb_q.push_back(e);
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check_value("dev_sel", 32'(obs_sel), bad ? 32'h0 : (32'h1 << idx));
                if (!bad) begin
                    check_value("dev_we", 32'(obs_we), 32'(we));
                    check_value("dev_addr", 32'(obs_addr), 32'(addr[5:0]));
                    check_value("dev_wdata", obs_wdata, wdata);
                end
            end
            if (obs_ready) begin
                seen = 1'b1;
                got  = sb_q.pop_front();
                check_value("latency", 32'(n), 32'(got.lat));
                check_value("io_data_read", obs_rdata, got.data);
                check_value("io_err", 32'(obs_err), 32'(got.err));
                if (got.err) begin
                    if (t3) exp_cnt3 = (exp_cnt3 == 16'hFFFF) ? exp_cnt3 : exp_cnt3 + 16'd1;
                    else    exp_cnt4 = (exp_cnt4 == 16'hFFFF) ? exp_cnt4 : exp_cnt4 + 16'd1;
                end
                tb_en = 1'b0; tb_ack = '0;
            end else begin
                tb_ack = '0;
                if (!bad && d >= 0 && n == 1 + d) tb_ack[idx] = 1'b1;
                if (stray) tb_ack[3] = 1'b1;
            end
        end
        if (!seen) begin
            check_value("ready_seen", 32'h0, 32'h1);
            tb_en = 1'b0; tb_ack = '0;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        @(negedge clk);
        check_value("ready_pulse_end", 32'(obs_ready), 32'h0);
        check_value("dev_sel_idle", 32'(obs_sel), 32'h0);
        check_value("err_count", 32'(obs_cnt), 32'(t3 ? exp_cnt3 : exp_cnt4));
    endtask

    task automatic reset_mid_access();
        int hits;
        @(negedge clk);
        tgt3 = 1'b0; tb_addr = 8'h41; tb_we = 1'b0; tb_wdata = 32'h0; tb_en = 1'b1; tb_ack = '0;
        repeat (3) @(negedge clk);
        check_value("rst_pre_sel", 32'(obs_sel), 32'h2);
        reset = 1'b1; tb_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt4 = '0; exp_cnt3 = '0;
        check_value("rst_sel", 32'(obs_sel), 32'h0);
        check_value("rst_ready", 32'(obs_ready), 32'h0);
        check_value("rst_cnt", 32'(obs_cnt), 32'h0);
        check_value("rst_addr", 32'(obs_addr), 32'h0);
        hits = 0;
        repeat (TIMEOUT + 3) begin
            @(negedge clk);
            if (obs_ready) hits++;
        end
        check_value("rst_no_ready", 32'(hits), 32'h0);
    endtask

    initial begin
        reset = 1'b1; tb_en = 1'b0; tb_addr = '0; tb_we = 1'b0; tb_wdata = '0;
        tb_ack = '0; tb_rdata = '0; tgt3 = 1'b0;
        exp_cnt4 = '0; exp_cnt3 = '0;
        repeat (3) @(negedge clk);
        check_value("reset_ready", 32'(obs_ready), 32'h0);
        check_value("reset_err", 32'(obs_err), 32'h0);
        check_value("reset_rdata", obs_rdata, 32'h0);
        check_value("reset_cnt", 32'(obs_cnt), 32'h0);
        check_value("reset_sel", 32'(obs_sel), 32'h0);
        check_value("reset_we", 32'(obs_we), 32'h0);
        check_value("reset_addr", 32'(obs_addr), 32'h0);
        check_value("reset_wdata", obs_wdata, 32'h0);
        reset = 1'b0;

        do_access(1'b0, 8'h85, 1'b0, 32'h0,         0, 32'h1234_5678, 1'b0);
        do_access(1'b0, 8'h04, 1'b1, 32'hCAFE_F00D, 3, 32'h5555_AAAA, 1'b0);
        do_access(1'b0, 8'h41, 1'b0, 32'h0,        -1, 32'h0BAD_0001, 1'b0);
        do_access(1'b1, 8'hC0, 1'b0, 32'h0,         0, 32'h0000_0000, 1'b0);
        do_access(1'b1, 8'h80, 1'b0, 32'h0,         1, 32'h3333_0002, 1'b0);
        do_access(1'b0, 8'h10, 1'b0, 32'h0,         2, 32'hA5A5_0000, 1'b1);
        reset_mid_access();
        do_access(1'b0, 8'hC3, 1'b0, 32'h0,         1, 32'h7777_0003, 1'b0);

        @(negedge clk);
        tgt3 = 1'b1;
        force dut3.r_err_count = 16'hFFFE;
        @(negedge clk);
        release dut3.r_err_count;
        exp_cnt3 = 16'hFFFE;
        @(negedge clk);
        check_value("cnt_preload", 32'(obs_cnt), 32'(exp_cnt3));
        repeat (3) do_access(1'b1, 8'hC5, 1'b1, 32'h0000_0001, 0, 32'h0, 1'b0);

        check_value("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
